pico_bus_arbiter: RTL and testbench

Shares one PicoBus master port between NREQ local requesters, e.g. the host stream bridge and on-FPGA engines that program or poll PicoBus registers. Round-robin grant with burst hold and a beat cap, registered PicoBus drive, and fixed-latency read-data routing back to the issuing requester. Sits between the requesters and the PicoBus slaves, in the same clock domain as the stream bridge.

---
 rtl/pico_bus_arb_pkg.sv | 20 ++
 rtl/pico_rr_pick.sv | 35 +++
 rtl/pico_bus_arbiter.sv | 155 +++++++++++++++
 tb/tb_pico_bus_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pico_bus_arb_pkg.sv
// Shared constants and helpers for the PicoBus arbiter and its round-robin picker.
package pico_bus_arb_pkg;

  localparam int PICO_ADDR_W = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARB  = 2'd1;
  localparam logic [1:0] ST_OWN  = 2'd2;

  // Ceiling log2, usable in parameter expressions (clog2(1) = 0).
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/pico_rr_pick.sv
// Round-robin picker: first set request after index 'last', wrapping modulo NREQ.
module pico_rr_pick
  import pico_bus_arb_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int IDX_W = (NREQ > 1) ? clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last,
  output logic [NREQ-1:0]  pick,
  output logic [IDX_W-1:0] pick_idx
);

  localparam int CW = IDX_W + 1;

  // One extra bit holds last+k before the wrap back below NREQ.
  always_comb begin
    logic [CW-1:0] cand;
    logic          found;
    pick     = '0;
    pick_idx = '0;
    found    = 1'b0;
    cand     = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = {1'b0, last} + CW'(k);
      if (cand >= CW'(NREQ)) cand = cand - CW'(NREQ);
      if (!found && req[cand[IDX_W-1:0]]) begin
        found                 = 1'b1;
        pick[cand[IDX_W-1:0]] = 1'b1;
        pick_idx              = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/pico_bus_arbiter.sv
// Shares one PicoBus master port between NREQ requesters: round-robin grant with
// burst hold and beat cap, registered bus drive, fixed-latency read-data routing.
module pico_bus_arbiter
  import pico_bus_arb_pkg::*;
#(
  parameter int NREQ       = 2,
  parameter int W          = 128,
  parameter int RD_LATENCY = 1,
  parameter int MAX_BEATS  = 16
) (
  input  logic                        s_clk,
  input  logic                        s_rst_n,
  input  logic [NREQ-1:0]             req_valid,
  input  logic [NREQ-1:0]             req_rd,
  input  logic [NREQ-1:0]             req_last,
  input  logic [NREQ*PICO_ADDR_W-1:0] req_addr,
  input  logic [NREQ*W-1:0]           req_wdata,
  output logic [NREQ-1:0]             req_ready,
  output logic [NREQ-1:0]             grant,
  output logic [NREQ-1:0]             rsp_valid,
  output logic [W-1:0]                rsp_data,
  output logic                        PicoWr,
  output logic                        PicoRd,
  output logic [PICO_ADDR_W-1:0]      PicoAddr,
  output logic [W-1:0]                PicoDataIn,
  input  logic [W-1:0]                PicoDataOut
);

  localparam int IDX_W    = clog2(NREQ);
  localparam int ADDR_LSB = clog2(W / 8);
  localparam int BCNT_W   = clog2(MAX_BEATS) + 1;
  localparam logic [PICO_ADDR_W-1:0] ADDR_MASK =
    ~((PICO_ADDR_W'(1) << ADDR_LSB) - PICO_ADDR_W'(1));

  logic [1:0]             state;
  logic [IDX_W-1:0]       last_grant;
  logic [BCNT_W-1:0]      beat_cnt;
  logic [NREQ-1:0]        pick;
  logic [IDX_W-1:0]       pick_idx;
  logic                   accept;
  logic                   release_burst;
  logic                   sel_rd;
  logic                   sel_last;
  logic [PICO_ADDR_W-1:0] sel_addr;
  logic [W-1:0]           sel_wdata;
  logic [RD_LATENCY:0]    pipe_vld;
  logic [IDX_W-1:0]       pipe_idx [RD_LATENCY:0];

  pico_rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req      (req_valid),
    .last     (last_grant),
    .pick     (pick),
    .pick_idx (pick_idx)
  );

  // grant is only non-zero in OWN, so this is the whole ready decode.
  assign req_ready = grant & req_valid;
  assign accept    = |req_ready;

  always_comb begin
    sel_rd    = 1'b0;
    sel_last  = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_rd    = req_rd[i];
        sel_last  = req_last[i];
        sel_addr  = req_addr[PICO_ADDR_W*i +: PICO_ADDR_W];
        sel_wdata = req_wdata[W*i +: W];
      end
    end
  end

  assign release_burst = accept && (sel_last || (beat_cnt == BCNT_W'(MAX_BEATS - 1)));

  always_ff @(posedge s_clk) begin
    if (!s_rst_n) begin
      state      <= ST_IDLE;
      grant      <= '0;
      last_grant <= IDX_W'(NREQ - 1);
      beat_cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|req_valid) state <= ST_ARB;
        end
        ST_ARB: begin
          if (|req_valid) begin
            grant      <= pick;
            last_grant <= pick_idx;
            beat_cnt   <= '0;
            state      <= ST_OWN;
          end else begin
            grant <= '0;
            state <= ST_IDLE;
          end
        end
        ST_OWN: begin
          if (accept) begin
            beat_cnt <= beat_cnt + BCNT_W'(1);
            if (release_burst) begin
              grant <= '0;
              state <= ST_IDLE;
            end
          end
        end
        default: begin
          grant <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge s_clk) begin
    if (!s_rst_n) begin
      PicoWr     <= 1'b0;
      PicoRd     <= 1'b0;
      PicoAddr   <= '0;
      PicoDataIn <= '0;
    end else begin
      PicoWr <= accept & ~sel_rd;
      PicoRd <= accept & sel_rd;
      if (accept) begin
        PicoAddr   <= sel_addr & ADDR_MASK;
        PicoDataIn <= sel_wdata;
      end
    end
  end

  // Stage 0 lines up with the PicoRd cycle; stage RD_LATENCY with valid PicoDataOut.
  // last_grant names the owner while in OWN, so it tags the read directly.
  always_ff @(posedge s_clk) begin
    if (!s_rst_n) begin
      pipe_vld  <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      for (int i = 0; i <= RD_LATENCY; i++) pipe_idx[i] <= '0;
    end else begin
      pipe_vld    <= {pipe_vld[RD_LATENCY-1:0], accept & sel_rd};
      pipe_idx[0] <= last_grant;
      for (int i = 1; i <= RD_LATENCY; i++) pipe_idx[i] <= pipe_idx[i-1];
      rsp_valid <= '0;
      if (pipe_vld[RD_LATENCY]) begin
        rsp_valid[pipe_idx[RD_LATENCY]] <= 1'b1;
        rsp_data                        <= PicoDataOut;
      end
    end
  end

endmodule

// File: tb/tb_pico_bus_arbiter.sv
// Directed bench for pico_bus_arbiter: two requesters, W=128, RD_LATENCY=1, MAX_BEATS=4.
module tb_pico_bus_arbiter;

  localparam int NREQ       = 2;
  localparam int W          = 128;
  localparam int RD_LATENCY = 1;
  localparam int MAX_BEATS  = 4;
  localparam logic [W-1:0] IDLE_DATA = {4{32'hDEADBEEF}};

  typedef struct packed {
    logic         rd;
    logic         last;
    logic [31:0]  addr;
    logic [W-1:0] data;
  } beat_t;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_rd;
  logic [NREQ-1:0]   req_last;
  logic [NREQ*32-1:0] req_addr;
  logic [NREQ*W-1:0] req_wdata;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   rsp_valid;
  logic [W-1:0]      rsp_data;
  logic              pico_wr;
  logic              pico_rd;
  logic [31:0]       pico_addr;
  logic [W-1:0]      pico_data_in;
  logic [W-1:0]      pico_data_out;

  beat_t        q0[$];
  beat_t        q1[$];
  logic         pend_valid;
  logic [W-1:0] pend_data;
  logic [W-1:0] slave_base;
  int           n_checks;
  int           n_fail;

  pico_bus_arbiter #(
    .NREQ       (NREQ),
    .W          (W),
    .RD_LATENCY (RD_LATENCY),
    .MAX_BEATS  (MAX_BEATS)
  ) dut (
    .s_clk       (clk),
    .s_rst_n     (rst_n),
    .req_valid   (req_valid),
    .req_rd      (req_rd),
    .req_last    (req_last),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_ready   (req_ready),
    .grant       (grant),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .PicoWr      (pico_wr),
    .PicoRd      (pico_rd),
    .PicoAddr    (pico_addr),
    .PicoDataIn  (pico_data_in),
    .PicoDataOut (pico_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic beat_t mk_beat(input logic rd, input logic last,
                                    input logic [31:0] addr, input logic [W-1:0] data);
    beat_t b;
    b.rd = rd; b.last = last; b.addr = addr; b.data = data;
    return b;
  endfunction

  task automatic drive_inputs();
    beat_t b;
    req_valid = '0; req_rd = '0; req_last = '0; req_addr = '0; req_wdata = '0;
    if (q0.size() > 0) begin
      b = q0[0];
      req_valid[0] = 1'b1; req_rd[0] = b.rd; req_last[0] = b.last;
      req_addr[31:0] = b.addr; req_wdata[W-1:0] = b.data;
    end
    if (q1.size() > 0) begin
      b = q1[0];
      req_valid[1] = 1'b1; req_rd[1] = b.rd; req_last[1] = b.last;
      req_addr[63:32] = b.addr; req_wdata[2*W-1:W] = b.data;
    end
  endtask

  // One clock: note handshakes mid-cycle, then after the edge pop accepted beats,
  // advance the slave (data valid the cycle after PicoRd) and re-drive inputs.
  task automatic tick();
    logic [1:0] acc;
    beat_t      dummy;
    @(negedge clk);
    acc = req_valid & req_ready & {2{rst_n}};
    @(posedge clk);
    #1;
    if (acc[0]) dummy = q0.pop_front();
    if (acc[1]) dummy = q1.pop_front();
    pico_data_out = pend_valid ? pend_data : IDLE_DATA;
    pend_valid    = (pico_rd === 1'b1);
    pend_data     = slave_base + W'(pico_addr);
    drive_inputs();
  endtask

  task automatic apply_reset();
    q0.delete(); q1.delete();
    pend_valid = 1'b0;
    rst_n = 1'b0;
    drive_inputs();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_inputs();
    tick(); tick();
    n_checks++; if (grant !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_grant: got %b want 00", grant); end
    n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_ready: got %b want 00", req_ready); end
    n_checks++; if (rsp_valid !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_rsp_valid: got %b want 00", rsp_valid); end
    n_checks++; if (pico_wr !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_wr: got %b want 0", pico_wr); end
    n_checks++; if (pico_rd !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_rd: got %b want 0", pico_rd); end
    n_checks++; if (pico_addr !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_addr: got %h want 0", pico_addr); end
    n_checks++; if (pico_data_in !== '0) begin n_fail++; $display("[TB] FAIL reset_wdata: got %h want 0", pico_data_in); end
    n_checks++; if (rsp_data !== '0) begin n_fail++; $display("[TB] FAIL reset_rsp_data: got %h want 0", rsp_data); end
    rst_n = 1'b1;
    tick();
    n_checks++; if (grant !== 2'b00) begin n_fail++; $display("[TB] FAIL idle_grant: got %b want 00", grant); end
  endtask

  task automatic test_single_write();
    logic [W-1:0] wd;
    wd = {16{8'hA5}};
    q0.push_back(mk_beat(1'b0, 1'b1, 32'h0000_101F, wd));
    drive_inputs();
    tick();
    n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("[TB] FAIL wr_arb_ready: got %b want 00", req_ready); end
    tick();
    n_checks++; if (grant !== 2'b01) begin n_fail++; $display("[TB] FAIL wr_grant: got %b want 01", grant); end
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("[TB] FAIL wr_ready: got %b want 01", req_ready); end
    tick();
    n_checks++; if (pico_wr !== 1'b1) begin n_fail++; $display("[TB] FAIL wr_strobe: got %b want 1", pico_wr); end
    n_checks++; if (pico_rd !== 1'b0) begin n_fail++; $display("[TB] FAIL wr_no_rd: got %b want 0", pico_rd); end
    n_checks++; if (pico_addr !== 32'h0000_1010) begin n_fail++; $display("[TB] FAIL wr_addr: got %h want 00001010", pico_addr); end
    n_checks++; if (pico_data_in !== wd) begin n_fail++; $display("[TB] FAIL wr_data: got %h want %h", pico_data_in, wd); end
    n_checks++; if (grant !== 2'b00) begin n_fail++; $display("[TB] FAIL wr_release: got %b want 00", grant); end
    tick();
    n_checks++; if (pico_wr !== 1'b0) begin n_fail++; $display("[TB] FAIL wr_single_cycle: got %b want 0", pico_wr); end
    n_checks++; if (pico_addr !== 32'h0000_1010) begin n_fail++; $display("[TB] FAIL wr_addr_hold: got %h want 00001010", pico_addr); end
  endtask

  task automatic test_single_read();
    slave_base = W'(32'h1234);
    q0.push_back(mk_beat(1'b1, 1'b1, 32'h0000_0000, '0));
    drive_inputs();
    tick(); tick(); tick();
    n_checks++; if (pico_rd !== 1'b1) begin n_fail++; $display("[TB] FAIL rd_strobe: got %b want 1", pico_rd); end
    n_checks++; if (pico_wr !== 1'b0) begin n_fail++; $display("[TB] FAIL rd_no_wr: got %b want 0", pico_wr); end
    tick();
    n_checks++; if (rsp_valid !== 2'b00) begin n_fail++; $display("[TB] FAIL rd_early_rsp: got %b want 00", rsp_valid); end
    tick();
    n_checks++; if (rsp_valid !== 2'b01) begin n_fail++; $display("[TB] FAIL rd_rsp_valid: got %b want 01", rsp_valid); end
    n_checks++; if (rsp_data !== W'(32'h1234)) begin n_fail++; $display("[TB] FAIL rd_rsp_data: got %h want 1234", rsp_data); end
    tick();
    n_checks++; if (rsp_valid !== 2'b00) begin n_fail++; $display("[TB] FAIL rd_rsp_pulse: got %b want 00", rsp_valid); end
  endtask

  task automatic test_contention();
    logic        exp_wr   [0:31];
    logic [31:0] exp_addr [0:31];
    logic [1:0]  exp_gnt  [0:31];
    int          owner;
    int          start;
    apply_reset();
    for (int c = 0; c < 32; c++) begin exp_wr[c] = 1'b0; exp_addr[c] = '0; exp_gnt[c] = '0; end
    // Bursts alternate 0,1,0,1; each takes 4 bus cycles plus 2 dead cycles.
    for (int b = 0; b < 4; b++) begin
      owner = b % 2;
      start = 3 + 6 * b;
      for (int j = 0; j < 4; j++) begin
        exp_wr[start+j]   = 1'b1;
        exp_addr[start+j] = (owner == 0 ? 32'h0000_0100 : 32'h0001_0000) + 32'(16 * (4 * (b / 2) + j));
        exp_gnt[start-1+j] = 2'(1 << owner);
      end
    end
    for (int k = 0; k < 8; k++) begin
      q0.push_back(mk_beat(1'b0, (k % 4) == 3, 32'h0000_0100 + 32'(16 * k), W'(k)));
      q1.push_back(mk_beat(1'b0, (k % 4) == 3, 32'h0001_0000 + 32'(16 * k), W'(k + 100)));
    end
    drive_inputs();
    for (int c = 1; c <= 26; c++) begin
      tick();
      n_checks++; if (pico_wr !== exp_wr[c]) begin n_fail++; $display("[TB] FAIL cont_wr c%0d: got %b want %b", c, pico_wr, exp_wr[c]); end
      n_checks++; if (grant !== exp_gnt[c]) begin n_fail++; $display("[TB] FAIL cont_grant c%0d: got %b want %b", c, grant, exp_gnt[c]); end
      if (exp_wr[c]) begin
        n_checks++; if (pico_addr !== exp_addr[c]) begin n_fail++; $display("[TB] FAIL cont_addr c%0d: got %h want %h", c, pico_addr, exp_addr[c]); end
      end
    end
  endtask

  task automatic test_beat_cap();
    int          seg_owner [0:3];
    int          seg_start [0:3];
    int          seg_n     [0:3];
    int          seg_first [0:3];
    logic        exp_wr   [0:31];
    logic [31:0] exp_addr [0:31];
    logic [1:0]  exp_gnt  [0:31];
    logic [31:0] a;
    apply_reset();
    seg_owner = '{1, 0, 1, 1};
    seg_start = '{3, 9, 14, 20};
    seg_n     = '{4, 3, 4, 2};
    seg_first = '{0, 0, 4, 8};
    for (int c = 0; c < 32; c++) begin exp_wr[c] = 1'b0; exp_addr[c] = '0; exp_gnt[c] = '0; end
    for (int s = 0; s < 4; s++) begin
      for (int j = 0; j < seg_n[s]; j++) begin
        exp_wr[seg_start[s]+j]    = 1'b1;
        exp_addr[seg_start[s]+j]  = (seg_owner[s] == 0 ? 32'h0003_0000 : 32'h0002_0000) + 32'(16 * (seg_first[s] + j));
        exp_gnt[seg_start[s]-1+j] = 2'(1 << seg_owner[s]);
      end
    end
    for (int k = 0; k < 10; k++) begin
      a = 32'h0002_0000 + 32'(16 * k);
      q1.push_back(mk_beat(1'b0, k == 9, a, {a, a, a, a}));
    end
    drive_inputs();
    for (int c = 1; c <= 23; c++) begin
      tick();
      if (c == 2) begin
        for (int k = 0; k < 3; k++) begin
          a = 32'h0003_0000 + 32'(16 * k);
          q0.push_back(mk_beat(1'b0, k == 2, a, {a, a, a, a}));
        end
        drive_inputs();
      end
      n_checks++; if (pico_wr !== exp_wr[c]) begin n_fail++; $display("[TB] FAIL cap_wr c%0d: got %b want %b", c, pico_wr, exp_wr[c]); end
      n_checks++; if (grant !== exp_gnt[c]) begin n_fail++; $display("[TB] FAIL cap_grant c%0d: got %b want %b", c, grant, exp_gnt[c]); end
      if (exp_wr[c]) begin
        a = exp_addr[c];
        n_checks++; if (pico_addr !== a) begin n_fail++; $display("[TB] FAIL cap_addr c%0d: got %h want %h", c, pico_addr, a); end
        n_checks++; if (pico_data_in !== {a, a, a, a}) begin n_fail++; $display("[TB] FAIL cap_data c%0d: got %h want %h", c, pico_data_in, {a, a, a, a}); end
      end
    end
  endtask

  task automatic test_read_handover();
    logic [1:0]   exp_rv [0:15];
    logic [W-1:0] exp_rd [0:15];
    apply_reset();
    slave_base = W'(32'h5000);
    for (int c = 0; c < 16; c++) begin exp_rv[c] = 2'b00; exp_rd[c] = '0; end
    exp_rv[5] = 2'b01; exp_rd[5] = W'(32'h5040);
    exp_rv[6] = 2'b01; exp_rd[6] = W'(32'h5050);
    exp_rv[9] = 2'b10; exp_rd[9] = W'(32'h5080);
    q0.push_back(mk_beat(1'b1, 1'b0, 32'h40, '0));
    q0.push_back(mk_beat(1'b1, 1'b1, 32'h50, '0));
    q1.push_back(mk_beat(1'b1, 1'b1, 32'h80, '0));
    drive_inputs();
    for (int c = 1; c <= 11; c++) begin
      tick();
      n_checks++; if (rsp_valid !== exp_rv[c]) begin n_fail++; $display("[TB] FAIL ho_rsp_valid c%0d: got %b want %b", c, rsp_valid, exp_rv[c]); end
      if (exp_rv[c] != 2'b00) begin
        n_checks++; if (rsp_data !== exp_rd[c]) begin n_fail++; $display("[TB] FAIL ho_rsp_data c%0d: got %h want %h", c, rsp_data, exp_rd[c]); end
      end
      if (c == 6) begin
        n_checks++; if (grant !== 2'b10) begin n_fail++; $display("[TB] FAIL ho_grant: got %b want 10", grant); end
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    int guard;
    apply_reset();
    slave_base = W'(32'h7000);
    q1.push_back(mk_beat(1'b1, 1'b0, 32'h200, '0));
    q1.push_back(mk_beat(1'b1, 1'b0, 32'h210, '0));
    q1.push_back(mk_beat(1'b1, 1'b1, 32'h220, '0));
    drive_inputs();
    tick(); tick(); tick();
    n_checks++; if (pico_rd !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_rd_inflight: got %b want 1", pico_rd); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    q0.push_back(mk_beat(1'b0, 1'b1, 32'h300, W'(32'h33)));
    drive_inputs();
    n_checks++; if (grant !== 2'b00) begin n_fail++; $display("[TB] FAIL mid_grant: got %b want 00", grant); end
    n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("[TB] FAIL mid_ready: got %b want 00", req_ready); end
    n_checks++; if (pico_rd !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_rd: got %b want 0", pico_rd); end
    n_checks++; if (pico_wr !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_wr: got %b want 0", pico_wr); end
    n_checks++; if (pico_addr !== 32'h0) begin n_fail++; $display("[TB] FAIL mid_addr: got %h want 0", pico_addr); end
    n_checks++; if (pico_data_in !== '0) begin n_fail++; $display("[TB] FAIL mid_wdata: got %h want 0", pico_data_in); end
    n_checks++; if (rsp_valid !== 2'b00) begin n_fail++; $display("[TB] FAIL mid_rsp_valid: got %b want 00", rsp_valid); end
    n_checks++; if (rsp_data !== '0) begin n_fail++; $display("[TB] FAIL mid_rsp_data: got %h want 0", rsp_data); end
    tick();
    n_checks++; if (rsp_valid !== 2'b00) begin n_fail++; $display("[TB] FAIL mid_dropped_rsp: got %b want 00", rsp_valid); end
    tick();
    n_checks++; if (grant !== 2'b01) begin n_fail++; $display("[TB] FAIL mid_regrant: got %b want 01", grant); end
    n_checks++; if (rsp_valid !== 2'b00) begin n_fail++; $display("[TB] FAIL mid_late_rsp: got %b want 00", rsp_valid); end
    guard = 0;
    while ((q0.size() + q1.size()) > 0 && guard < 40) begin
      tick();
      guard++;
    end
    n_checks++; if ((q0.size() + q1.size()) != 0) begin n_fail++; $display("[TB] FAIL mid_drain: %0d beats left want 0", q0.size() + q1.size()); end
    repeat (6) tick();
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    pend_valid    = 1'b0;
    pend_data     = '0;
    slave_base    = '0;
    pico_data_out = IDLE_DATA;
    rst_n         = 1'b0;
    drive_inputs();
    test_reset();
    test_single_write();
    test_single_read();
    test_contention();
    test_beat_cap();
    test_read_handover();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
